instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 91 +++++++++
 tb/tb_instr_fetch.sv | 134 +++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch unit with redirect and valid/ready output.
// Optional MISALIGN_CHECK_EN enables misaligned-redirect faulting with a HALT state.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        misalign_fault
);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, HOLD, DRAIN, HALT} state_t;
    state_t state, state_n;
    logic [31:0] pc, pc_n, instr_n, instr_pc_n, target;
    logic valid_n, fault_n, halt_pend, halt_pend_n, bad, in_flight;
`ifdef MISALIGN_CHECK_EN
    assign target = redirect_pc;
    assign bad    = |redirect_pc[1:0];
`else
    logic unused_lsb;
    assign unused_lsb = ^redirect_pc[1:0];
    assign target     = {redirect_pc[31:2], 2'b00};
    assign bad        = 1'b0;
`endif
    assign imem_req  = state == FETCH;
    assign imem_addr = pc;
    // a request is still owed a response if it was issued this cycle or nothing came back yet
    assign in_flight = state == FETCH || ((state == WAIT || state == DRAIN) && !imem_rvalid);
    always_comb begin
        state_n     = state;
        pc_n        = pc;
        instr_n     = instr;
        instr_pc_n  = instr_pc;
        valid_n     = instr_valid;
        fault_n     = misalign_fault;
        halt_pend_n = halt_pend;
        case (state)
            IDLE:  state_n = FETCH;
            FETCH: state_n = WAIT;
            WAIT: if (imem_rvalid) begin
                instr_n    = imem_rdata;
                instr_pc_n = pc;
                valid_n    = 1'b1;
                pc_n       = pc + 32'd4;
                state_n    = HOLD;
            end
            HOLD: if (instr_ready) begin
                valid_n = 1'b0;
                state_n = FETCH;
            end
            DRAIN: if (imem_rvalid) state_n = halt_pend ? HALT : FETCH;
            HALT:  state_n = HALT;
            default: state_n = IDLE;
        endcase
        // redirect issued alongside a live request waits in DRAIN so only one request is ever outstanding
        if (redirect_en && state != IDLE) begin
            pc_n        = target;
            valid_n     = 1'b0;
            fault_n     = bad;
            halt_pend_n = bad;
            state_n     = in_flight ? DRAIN : (bad ? HALT : FETCH);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            instr          <= 32'd0;
            instr_pc       <= 32'd0;
            instr_valid    <= 1'b0;
            misalign_fault <= 1'b0;
            halt_pend      <= 1'b0;
        end else begin
            state          <= state_n;
            pc             <= pc_n;
            instr          <= instr_n;
            instr_pc       <= instr_pc_n;
            instr_valid    <= valid_n;
            misalign_fault <= fault_n;
            halt_pend      <= halt_pend_n;
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized scoreboard bench for instr_fetch with a transaction-level fetch model.
module tb_instr_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    logic clk = 0, rst = 1, imem_rvalid = 0, redirect_en = 0, instr_ready = 0;
    logic imem_req, instr_valid, misalign_fault;
    logic [31:0] imem_addr, imem_rdata = 0, redirect_pc = 0, instr, instr_pc;

    instr_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .misalign_fault(misalign_fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [31:0] data; logic [31:0] pc;} item_t;
    item_t q[$];
    int checks = 0, errors = 0;
    logic [31:0] exp_pc = RESET_PC, out_addr = 0, force_pc = 0;
    logic outstanding = 0, stale = 0, halted = 0, fault = 0, boot = 0, want = 0, fixed_data = 0;
    int mem_cnt = 0, lat_min = 2, lat_max = 2, ready_pct = 100, redir_pct = 0, rst_pml = 0;
    int rst_cnt = 3, force_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // drive one cycle of stimulus, then advance the reference model with what happened in it
    task automatic step();
        logic [31:0] tgt;
        @(negedge clk);
        if (force_mode == 3 && outstanding) begin rst_cnt = 3; force_mode = 0; end
        if (rst_cnt == 0 && $urandom_range(999) < rst_pml) rst_cnt = 3;
        rst = rst_cnt > 0;
        if (rst_cnt > 0) rst_cnt--;
        imem_rvalid = 0;
        if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_rvalid = 1;
                imem_rdata  = fixed_data ? 32'h0050_0093 : $urandom;
            end
        end
        instr_ready = $urandom_range(99) < ready_pct;
        if (force_mode == 1 || (force_mode == 2 && outstanding)) begin
            redirect_en = 1; redirect_pc = force_pc; force_mode = 0;
        end else begin
            redirect_en = $urandom_range(99) < redir_pct; redirect_pc = $urandom;
        end
        #2;
        if (rst) begin
            q.delete();
            outstanding = 0; stale = 0; halted = 0; fault = 0; want = 0; boot = 1;
            exp_pc = RESET_PC;
            if (mem_cnt > 3) mem_cnt = 0;
        end else begin
            chk("imem_req", imem_req, want);
            if (imem_req) begin
                chk("imem_addr", imem_addr, exp_pc);
                outstanding = 1; stale = 0; out_addr = exp_pc;
                mem_cnt = $urandom_range(lat_max, lat_min);
            end
            if (boot) begin
                boot = 0; want = 1;
            end else begin
                if (imem_rvalid && outstanding) begin
                    outstanding = 0;
                    if (!stale && !redirect_en) begin
                        q.push_back('{data: imem_rdata, pc: out_addr});
                        exp_pc = out_addr + 32'd4;
                    end
                end
                if (redirect_en) begin
`ifdef MISALIGN_CHECK_EN
                    tgt = redirect_pc;
                    halted = redirect_pc[1:0] != 2'b00;
                    fault  = halted;
`else
                    tgt = {redirect_pc[31:2], 2'b00};
`endif
                    q.delete();
                    exp_pc = tgt;
                    if (outstanding) stale = 1;
                end
                want = !outstanding && q.size() == 0 && !halted;
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        #1;
        chk("instr_valid", instr_valid, q.size() != 0);
        chk("misalign_fault", misalign_fault, fault);
        if (instr_valid && q.size() != 0) begin
            chk("instr", instr, q[0].data);
            chk("instr_pc", instr_pc, q[0].pc);
            if (instr_ready) void'(q.pop_front());
        end
    end

    initial begin
        step();
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_imem_req", imem_req, 1'b0);
        fixed_data = 1;
        repeat (22) step();
        ready_pct = 0;
        repeat (12) step();
        ready_pct = 100;
        repeat (10) step();
        lat_min = 3; lat_max = 3; force_mode = 2; force_pc = 32'h0000_0100;
        repeat (20) step();
        lat_min = 2; lat_max = 2; force_mode = 1; force_pc = 32'hFFFF_FFF8;
        repeat (20) step();
        force_mode = 2; force_pc = 32'h0000_0102;
        repeat (15) step();
        force_mode = 1; force_pc = 32'h0000_0200;
        repeat (15) step();
        force_mode = 3;
        repeat (20) step();
        fixed_data = 0; lat_min = 1; lat_max = 4; ready_pct = 70; redir_pct = 5; rst_pml = 3;
        repeat (3000) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
